// File: rtl/adc_multi_scaler.sv
// Multi-channel block averager followed by a pipelined multiply/shift scaler
// with saturation. Samples arrive tagged with a channel index; results leave in completion order.
module adc_multi_scaler #(
    parameter int          NUM_CH  = 4,
    parameter int          DATA_W  = 16,
    parameter int          AVG_POW = 8,
    parameter int unsigned SCALE   = 79993,
    parameter int          SHIFT   = 19,
    parameter int          OUT_W   = 16,
    parameter int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [CH_W-1:0]   s_ch,
    input  logic [DATA_W-1:0] s_data,
    input  logic              flush,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_avg,
    output logic [OUT_W-1:0]  out_scaled,
    output logic              out_sat,
    output logic              ch_err
);

    localparam int ACC_W  = DATA_W + AVG_POW;
    localparam int CNT_W  = (AVG_POW > 0) ? AVG_POW : 1;
    localparam int PROD_W = DATA_W + $clog2(SCALE) + 1;
    localparam logic [PROD_W-1:0] OUT_MAX = PROD_W'({OUT_W{1'b1}});

    logic in_range;
    logic take;
    assign in_range = ({1'b0, s_ch} < (CH_W + 1)'(NUM_CH));
    assign take     = s_valid && in_range;

    logic [ACC_W-1:0] acc_reg [NUM_CH];
    logic [CNT_W-1:0] cnt_reg [NUM_CH];
    logic [ACC_W-1:0] sum_w   [NUM_CH];
    logic             last_w  [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             hit;
            logic [ACC_W-1:0] base_acc;
            logic [CNT_W-1:0] base_cnt;

            // A flush in the same cycle as a sample makes that sample the first of a fresh block.
            assign hit        = take && (s_ch == CH_W'(gi));
            assign base_acc   = flush ? '0 : acc_reg[gi];
            assign base_cnt   = flush ? '0 : cnt_reg[gi];
            assign sum_w[gi]  = base_acc + ACC_W'(s_data);
            assign last_w[gi] = (AVG_POW == 0) || (base_cnt == {CNT_W{1'b1}});

            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_reg[gi] <= '0;
                    cnt_reg[gi] <= '0;
                end else if (hit) begin
                    if (last_w[gi]) begin
                        acc_reg[gi] <= '0;
                        cnt_reg[gi] <= '0;
                    end else begin
                        acc_reg[gi] <= sum_w[gi];
                        cnt_reg[gi] <= base_cnt + 1'b1;
                    end
                end else if (flush) begin
                    acc_reg[gi] <= '0;
                    cnt_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    logic [ACC_W-1:0] sel_sum;
    logic             sel_last;

    always_comb begin
        sel_sum  = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_ch == CH_W'(i)) begin
                sel_sum  = sum_w[i];
                sel_last = last_w[i];
            end
        end
    end

    logic              v1_reg, v2_reg;
    logic [CH_W-1:0]   ch1_reg, ch2_reg;
    logic [DATA_W-1:0] avg1_reg, avg2_reg;
    logic [PROD_W-1:0] prod_reg;
    logic [PROD_W-1:0] q;

    assign q = prod_reg >> SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg     <= 1'b0;
            v2_reg     <= 1'b0;
            ch1_reg    <= '0;
            ch2_reg    <= '0;
            avg1_reg   <= '0;
            avg2_reg   <= '0;
            prod_reg   <= '0;
            ch_err     <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_avg    <= '0;
            out_scaled <= '0;
            out_sat    <= 1'b0;
        end else begin
            ch_err <= s_valid && !in_range;
            v1_reg <= take && sel_last;
            if (take && sel_last) begin
                avg1_reg <= DATA_W'(sel_sum >> AVG_POW);
                ch1_reg  <= s_ch;
            end

            v2_reg   <= v1_reg;
            prod_reg <= PROD_W'(avg1_reg) * PROD_W'(SCALE);
            avg2_reg <= avg1_reg;
            ch2_reg  <= ch1_reg;

            // Output fields only move when a result is delivered, so they hold while idle.
            out_valid <= v2_reg;
            if (v2_reg) begin
                out_ch  <= ch2_reg;
                out_avg <= avg2_reg;
                if (q > OUT_MAX) begin
                    out_scaled <= '1;
                    out_sat    <= 1'b1;
                end else begin
                    out_scaled <= OUT_W'(q);
                    out_sat    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_multi_scaler.sv
// Scoreboard bench: a default-parameter instance (averaging) and a no-averaging,
// saturating, five-channel instance (saturation and invalid-channel handling).
module tb_adc_multi_scaler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]  a_ch = '0;
    logic [2:0]  b_ch = '0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_out_valid, a_out_sat, a_ch_err;
    logic [1:0]  a_out_ch;
    logic [15:0] a_out_avg, a_out_scaled;
    logic        b_out_valid, b_out_sat, b_ch_err;
    logic [2:0]  b_out_ch;
    logic [15:0] b_out_avg, b_out_scaled;

    adc_multi_scaler dut_a (
        .clk(clk), .reset(reset), .s_valid(a_valid), .s_ch(a_ch), .s_data(a_data),
        .flush(flush), .out_valid(a_out_valid), .out_ch(a_out_ch), .out_avg(a_out_avg),
        .out_scaled(a_out_scaled), .out_sat(a_out_sat), .ch_err(a_ch_err)
    );

    adc_multi_scaler #(.NUM_CH(5), .AVG_POW(0), .SCALE(32'd1 << 20), .SHIFT(19)) dut_b (
        .clk(clk), .reset(reset), .s_valid(b_valid), .s_ch(b_ch), .s_data(b_data),
        .flush(flush), .out_valid(b_out_valid), .out_ch(b_out_ch), .out_avg(b_out_avg),
        .out_scaled(b_out_scaled), .out_sat(b_out_sat), .ch_err(b_ch_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int     ch;
        longint avg;
        longint scaled;
        int     sat;
        int     due;
    } exp_t;

    exp_t   qa[$];
    exp_t   qb[$];
    int     errq[$];
    longint acc_a[4];
    int     cnt_a[4];

    function automatic exp_t mk(int ch, longint avg, longint scale, int shift, int due);
        exp_t   e;
        longint q;
        q        = (avg * scale) >> shift;
        e.ch     = ch;
        e.avg    = avg;
        e.sat    = (q > 65535) ? 1 : 0;
        e.scaled = (q > 65535) ? 65535 : q;
        e.due    = due;
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            acc_a[i] = 0;
            cnt_a[i] = 0;
        end
    endtask

    task automatic drive_a(input int ch, input int data, input bit fl);
        a_valid = 1'b1;
        a_ch    = 2'(ch);
        a_data  = 16'(data);
        flush   = fl;
        if (fl) clear_model();
        acc_a[ch] += data;
        cnt_a[ch]++;
        if (cnt_a[ch] == 256) begin
            qa.push_back(mk(ch, acc_a[ch] >> 8, 79993, 19, cyc + 3));
            acc_a[ch] = 0;
            cnt_a[ch] = 0;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic drive_b(input int ch, input int data);
        b_valid = 1'b1;
        b_ch    = 3'(ch);
        b_data  = 16'(data);
        if (ch < 5) qb.push_back(mk(ch, data, 64'd1 << 20, 19, cyc + 3));
        else        errq.push_back(cyc + 1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (a_out_valid) begin
                if (qa.size() == 0) check("a_spurious_valid", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("a_ch", 64'(a_out_ch), 64'(e.ch));
                    check("a_avg", 64'(a_out_avg), 64'(e.avg));
                    check("a_scaled", 64'(a_out_scaled), 64'(e.scaled));
                    check("a_sat", 64'(a_out_sat), 64'(e.sat));
                    check("a_latency", 64'(cyc), 64'(e.due));
                end
            end
            if (b_out_valid) begin
                if (qb.size() == 0) check("b_spurious_valid", 1, 0);
                else begin
                    e = qb.pop_front();
                    check("b_ch", 64'(b_out_ch), 64'(e.ch));
                    check("b_avg", 64'(b_out_avg), 64'(e.avg));
                    check("b_scaled", 64'(b_out_scaled), 64'(e.scaled));
                    check("b_sat", 64'(b_out_sat), 64'(e.sat));
                    check("b_latency", 64'(cyc), 64'(e.due));
                end
            end
            if (errq.size() != 0 && errq[0] == cyc) begin
                void'(errq.pop_front());
                check("b_ch_err", 64'(b_ch_err), 1);
            end else if (b_ch_err) begin
                check("b_ch_err_spurious", 64'(b_ch_err), 0);
            end
            if (a_ch_err) check("a_ch_err_spurious", 64'(a_ch_err), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        clear_model();
        reset = 1'b1;
        idle(3);
        check("rst_a_valid", 64'(a_out_valid), 0);
        check("rst_a_avg", 64'(a_out_avg), 0);
        check("rst_a_scaled", 64'(a_out_scaled), 0);
        check("rst_a_sat_ch_err", 64'({a_out_sat, a_out_ch, a_ch_err}), 0);
        check("rst_b_outputs", 64'({b_out_valid, b_out_avg, b_out_scaled, b_out_sat, b_ch_err}), 0);
        reset = 1'b0;
        idle(1);

        // single channel block, then check idle hold
        for (int i = 0; i < 256; i++) drive_a(0, 'h4000, 1'b0);
        idle(6);
        check("hold_valid", 64'(a_out_valid), 0);
        check("hold_avg", 64'(a_out_avg), 'h4000);
        check("hold_scaled", 64'(a_out_scaled), 2499);

        // round-robin interleave over four channels
        for (int i = 0; i < 1024; i++) drive_a(i % 4, 'h1000 * (i % 4 + 1), 1'b0);
        idle(5);

        // saturation boundary, back-to-back results and invalid channels
        drive_b(0, 'h8000);
        drive_b(1, 'h7FFF);
        drive_b(2, 'h1234);
        drive_b(5, 'h5555);
        drive_b(7, 'hFFFF);
        drive_b(4, 'hFFFF);
        drive_b(3, 'h0010);
        idle(5);

        // reset mid-block discards the partial sum
        for (int i = 0; i < 100; i++) drive_a(1, 'hFFFF, 1'b0);
        reset = 1'b1;
        clear_model();
        idle(1);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) drive_a(1, 'h0010, 1'b0);
        idle(5);

        // flush coinciding with a sample starts a new block
        for (int i = 0; i < 200; i++) drive_a(2, 'h0100, 1'b0);
        drive_a(2, 'h0100, 1'b1);
        for (int i = 0; i < 255; i++) drive_a(2, 'h0100, 1'b0);
        idle(5);

        // random traffic with gaps and occasional flushes
        for (int i = 0; i < 1200; i++) begin
            drive_a($urandom_range(0, 3), $urandom_range(0, 65535), ($urandom_range(0, 199) == 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        for (int i = 0; i < 150; i++) begin
            drive_b($urandom_range(0, 7), $urandom_range(0, 65535));
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        idle(10);
        check("a_results_outstanding", 64'(qa.size()), 0);
        check("b_results_outstanding", 64'(qb.size()), 0);
        check("b_ch_err_outstanding", 64'(errq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
